// File: rtl/vga_timing_gen.sv
// VGA scan timing: pixel-tick divider, h/v counters, registered syncs aligned with the counters, frame/line strobes.
// Syncs share the counters' zero latency; free-running source with no backpressure input.
module vga_timing_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   TICK_DIV  = 2,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       line_end
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             tick;

    // Gating with reset keeps the strobe low while reset is held, including the TICK_DIV=1 case.
    assign tick = (div_q == DIV_LAST) && reset;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        // Decoding the next counter values keeps the sync registers in step with pixel_x/pixel_y.
        hsync_d = ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign p_tick      = tick;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = (x_q < H_VIS) && (y_q < V_VIS);
    assign frame_start = tick && (x_q == '0) && (y_q == '0);
    assign line_end    = tick && (x_q == H_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for reset/line timing, plus two small-raster instances
// (16x10 totals) so frame wrap, frame period, mid-frame reset and the TICK_DIV=1/SYNC_POL=1 build fit a short run.
module tb_vga_timing_gen;

    localparam int A_HT = 640 + 16 + 96 + 48;
    localparam int A_VT = 480 + 10 + 2 + 33;

    if (A_HT > 1024 || A_VT > 1024) begin : g_range_check
        $error("scan totals exceed the 10-bit counter range");
    end

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a, line_end_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b, line_end_b;
    logic [9:0] pixel_x_b, pixel_y_b;
    logic       p_tick_c, hsync_c, vsync_c, video_on_c, frame_start_c, line_end_c;
    logic [9:0] pixel_x_c, pixel_y_c;

    vga_timing_gen u_dut_a (
        .clk(clk), .reset(rst_a), .p_tick(p_tick_a), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
        .frame_start(frame_start_a), .line_end(line_end_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(2), .SYNC_POL(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .p_tick(p_tick_b), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
        .frame_start(frame_start_b), .line_end(line_end_b)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(1), .SYNC_POL(1'b1)
    ) u_dut_c (
        .clk(clk), .reset(rst_c), .p_tick(p_tick_c), .hsync(hsync_c), .vsync(vsync_c),
        .video_on(video_on_c), .pixel_x(pixel_x_c), .pixel_y(pixel_y_c),
        .frame_start(frame_start_c), .line_end(line_end_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n, cnt, first_x, last_x, per, vs_low, vs_bad;
        logic vo639, vo640;

        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        chk("a rst pixel_x", pixel_x_a, 0);
        chk("a rst pixel_y", pixel_y_a, 0);
        chk("a rst hsync", hsync_a, 1);
        chk("a rst vsync", vsync_a, 1);
        chk("a rst p_tick", p_tick_a, 0);
        chk("a rst video_on", video_on_a, 1);
        chk("a rst frame_start", frame_start_a, 0);
        chk("a rst line_end", line_end_a, 0);
        chk("c rst p_tick", p_tick_c, 0);
        chk("c rst hsync", hsync_c, 0);
        chk("c rst vsync", vsync_c, 0);

        // Release and first ticks
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        #1;
        chk("a release p_tick", p_tick_a, 0);
        chk("c release p_tick", p_tick_c, 1);
        @(negedge clk);
        chk("a clk1 p_tick", p_tick_a, 1);
        chk("a clk1 frame_start", frame_start_a, 1);
        chk("a clk1 pixel_x", pixel_x_a, 0);
        @(negedge clk);
        chk("a clk2 p_tick", p_tick_a, 0);
        chk("a clk2 frame_start", frame_start_a, 0);
        chk("a clk2 pixel_x", pixel_x_a, 1);
        @(negedge clk);
        chk("a clk3 p_tick", p_tick_a, 1);
        chk("a clk3 pixel_x", pixel_x_a, 1);

        // One full line (y=1), one sample per pixel
        n = 0;
        while (!(pixel_x_a == 0 && pixel_y_a == 1 && p_tick_a) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("a line1 start found", (pixel_x_a == 0 && pixel_y_a == 1 && p_tick_a), 1);
        cnt = 0; first_x = -1; last_x = -1; vo639 = 1'bx; vo640 = 1'bx;
        for (int i = 0; i < 1600; i++) begin
            if (p_tick_a) begin
                if (!hsync_a) begin
                    if (cnt == 0) first_x = int'(pixel_x_a);
                    last_x = int'(pixel_x_a);
                    cnt++;
                end
                if (pixel_x_a == 639) vo639 = video_on_a;
                if (pixel_x_a == 640) vo640 = video_on_a;
            end
            @(negedge clk);
        end
        chk("a hsync low ticks", cnt, 96);
        chk("a hsync first x", first_x, 656);
        chk("a hsync last x", last_x, 751);
        chk("a video_on x639", vo639, 1);
        chk("a video_on x640", vo640, 0);

        // Line wrap at (799,10)
        n = 0;
        while (!(pixel_x_a == 799 && pixel_y_a == 10) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("a x799 y10 found", (pixel_x_a == 799 && pixel_y_a == 10), 1);
        chk("a line_end without tick", line_end_a, 0);
        @(negedge clk);
        chk("a x799 p_tick", p_tick_a, 1);
        chk("a line_end", line_end_a, 1);
        chk("a line_end frame_start", frame_start_a, 0);
        @(negedge clk);
        chk("a wrap pixel_x", pixel_x_a, 0);
        chk("a wrap pixel_y", pixel_y_a, 11);
        chk("a wrap line_end cleared", line_end_a, 0);

        // Small raster: frame wrap at (15,9)
        n = 0;
        while (!(pixel_x_b == 15 && pixel_y_b == 9 && p_tick_b) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b x15 y9 tick found", (pixel_x_b == 15 && pixel_y_b == 9 && p_tick_b), 1);
        chk("b last line_end", line_end_b, 1);
        chk("b last frame_start", frame_start_b, 0);
        @(negedge clk);
        chk("b wrap pixel_x", pixel_x_b, 0);
        chk("b wrap pixel_y", pixel_y_b, 0);
        chk("b wrap frame_start no tick", frame_start_b, 0);
        @(negedge clk);
        chk("b frame_start", frame_start_b, 1);
        @(negedge clk);
        chk("b frame_start one clk", frame_start_b, 0);

        // Frame period and vsync window
        n = 0;
        while (!frame_start_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b frame_start seen", frame_start_b, 1);
        per = 0; vs_low = 0; vs_bad = 0;
        do begin
            @(negedge clk);
            per++;
            if (p_tick_b && !vsync_b) begin
                vs_low++;
                if (pixel_y_b < 7 || pixel_y_b > 8) vs_bad++;
            end
        end while (!frame_start_b && per < 1000);
        chk("b frame period clks", per, 320);
        chk("b vsync low ticks", vs_low, 32);
        chk("b vsync low outside 7..8", vs_bad, 0);

        // Mid-frame reset at (11,7), inside both sync pulses
        n = 0;
        while (!(pixel_x_b == 11 && pixel_y_b == 7) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b x11 y7 found", (pixel_x_b == 11 && pixel_y_b == 7), 1);
        chk("b pre-reset hsync", hsync_b, 0);
        chk("b pre-reset vsync", vsync_b, 0);
        rst_b = 1'b0;
        #1;
        chk("b midrst pixel_x", pixel_x_b, 0);
        chk("b midrst pixel_y", pixel_y_b, 0);
        chk("b midrst hsync", hsync_b, 1);
        chk("b midrst vsync", vsync_b, 1);
        chk("b midrst p_tick", p_tick_b, 0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("b rerelease p_tick", p_tick_b, 0);
        @(negedge clk);
        chk("b rerelease clk1 p_tick", p_tick_b, 1);
        chk("b rerelease clk1 frame_start", frame_start_b, 1);
        @(negedge clk);
        chk("b rerelease clk2 pixel_x", pixel_x_b, 1);
        chk("b rerelease clk2 p_tick", p_tick_b, 0);

        // TICK_DIV=1, SYNC_POL=1 build
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (p_tick_c) cnt++;
            @(negedge clk);
        end
        chk("c p_tick constant", cnt, 50);
        n = 0;
        while (pixel_x_c != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("c x0 found", pixel_x_c, 0);
        cnt = 0; first_x = -1;
        for (int i = 0; i < 16; i++) begin
            if (hsync_c) begin
                if (cnt == 0) first_x = int'(pixel_x_c);
                cnt++;
            end
            @(negedge clk);
        end
        chk("c hsync high ticks", cnt, 3);
        chk("c hsync first x", first_x, 10);
        n = 0;
        while (!frame_start_c && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("c frame_start seen", frame_start_c, 1);
        per = 0;
        do begin
            @(negedge clk);
            per++;
        end while (!frame_start_c && per < 1000);
        chk("c frame period clks", per, 160);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
